// File: rtl/lvds_panel_pkg.sv
// Shared definitions for the LVDS panel power sequencer: state encoding,
// default stage delays (62.5 MHz dot clock) and the stage-counter load helper.
package lvds_panel_pkg;

    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] CNT_ONE = 25'd1;

    // Default stage delays in dot-clock cycles
    localparam int unsigned T_VDD_LVDS_DEF     = 32'd3125000;   // 50 ms
    localparam int unsigned T_LVDS_BL_DEF      = 32'd12500000;  // 200 ms
    localparam int unsigned T_BL_LVDS_DEF      = 32'd12500000;  // 200 ms
    localparam int unsigned T_LVDS_VDD_DEF     = 32'd3125000;   // 50 ms
    localparam int unsigned T_OFF_MIN_DEF      = 32'd31250000;  // 500 ms
    localparam int unsigned T_SYNC_TIMEOUT_DEF = 32'd4194304;   // 2^22 cycles without a frame start

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_VDD_UP    = 4'd1,
        ST_LVDS_UP   = 4'd2,
        ST_SYNC_WAIT = 4'd3,
        ST_BL_WAIT   = 4'd4,
        ST_RUN       = 4'd5,
        ST_BL_DOWN   = 4'd6,
        ST_LVDS_DOWN = 4'd7,
        ST_OFF_HOLD  = 4'd8
    } panel_state_t;

    // A stage lasting t cycles loads t-1; the exit happens on the cycle the counter reads 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned t);
        return (t == 32'd0) ? '0 : CNT_W'(t - 32'd1);
    endfunction

endpackage

// File: rtl/panel_sync_in.sv
// Input conditioning: 2-flop synchroniser for the DCM LOCKED flag and a
// rising-edge detector on VSync (end of the active-low sync pulse = frame start).
module panel_sync_in (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clk_locked,
    input  logic i_vsync,
    output logic o_locked,
    output logic o_vsync_rise
);

    logic r_lock_meta;
    logic r_lock_sync;
    logic r_vsync_q;

    // Synchronise LOCKED into the dot-clock domain and keep last VSync level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_vsync_q   <= 1'b0;
        end else begin
            r_lock_meta <= i_clk_locked;
            r_lock_sync <= r_lock_meta;
            r_vsync_q   <= i_vsync;
        end
    end

    assign o_locked     = r_lock_sync;
    assign o_vsync_rise = i_vsync & ~r_vsync_q;

endmodule

// File: rtl/panel_power_sequencer.sv
// LVDS panel power sequencer: orders panel supply, serializer, video gate and
// backlight on power-up and power-down, enforcing every stage delay with one
// shared down-counter; loss of DCM lock forces a sticky fault and a full,
// orderly power-down.
module panel_power_sequencer
    import lvds_panel_pkg::*;
#(
    parameter int unsigned T_VDD_LVDS     = T_VDD_LVDS_DEF,
    parameter int unsigned T_LVDS_BL      = T_LVDS_BL_DEF,
    parameter int unsigned T_BL_LVDS      = T_BL_LVDS_DEF,
    parameter int unsigned T_LVDS_VDD     = T_LVDS_VDD_DEF,
    parameter int unsigned T_OFF_MIN      = T_OFF_MIN_DEF,
    parameter int unsigned T_SYNC_TIMEOUT = T_SYNC_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic panel_on,
    input  logic clk_locked,
    input  logic vsync,
    output logic panel_vdd,
    output logic lvds_en,
    output logic video_en,
    output logic backlight_en,
    output logic ready,
    output logic fault
);

    panel_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_panel_vdd;
    logic             r_lvds_en;
    logic             r_video_en;
    logic             r_backlight_en;
    logic             r_ready;
    logic             r_fault;

    logic w_locked;
    logic w_vsync_rise;
    logic w_lock_lost;
    logic w_abort;
    logic w_cnt_zero;

    panel_sync_in u_sync_in (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_locked (clk_locked),
        .i_vsync      (vsync),
        .o_locked     (w_locked),
        .o_vsync_rise (w_vsync_rise)
    );

    assign w_lock_lost = ~w_locked;
    assign w_abort     = ~panel_on | w_lock_lost;
    assign w_cnt_zero  = (r_cnt == '0);

    // Sequencer FSM: state, stage counter, sticky fault and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_OFF;
            r_cnt          <= '0;
            r_panel_vdd    <= 1'b0;
            r_lvds_en      <= 1'b0;
            r_video_en     <= 1'b0;
            r_backlight_en <= 1'b0;
            r_ready        <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            // Lock loss latches fault while the panel is (or may be) powered
            if (w_lock_lost && (r_state != ST_OFF) && (r_state != ST_OFF_HOLD)) begin
                r_fault <= 1'b1;
            end

            case (r_state)
                ST_OFF: begin
                    // A fault is acknowledged only by dropping the request while off
                    if (!panel_on) begin
                        r_fault <= 1'b0;
                    end
                    if (panel_on && w_locked && !r_fault) begin
                        r_state     <= ST_VDD_UP;
                        r_cnt       <= cnt_load(T_VDD_LVDS);
                        r_panel_vdd <= 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_VDD_UP: begin
                    // Serializer never started: skip straight to supply ramp-down
                    if (w_abort) begin
                        r_state <= ST_LVDS_DOWN;
                        r_cnt   <= cnt_load(T_LVDS_VDD);
                    end else if (w_cnt_zero) begin
                        r_state   <= ST_LVDS_UP;
                        r_cnt     <= cnt_load(32'd1);
                        r_lvds_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_LVDS_UP: begin
                    // One-cycle stage arming the frame-start search
                    if (w_abort) begin
                        r_state <= ST_BL_DOWN;
                        r_cnt   <= cnt_load(T_BL_LVDS);
                    end else begin
                        r_state <= ST_SYNC_WAIT;
                        r_cnt   <= cnt_load(T_SYNC_TIMEOUT);
                    end
                end
                ST_SYNC_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_BL_DOWN;
                        r_cnt   <= cnt_load(T_BL_LVDS);
                    end else if (w_vsync_rise) begin
                        r_state    <= ST_BL_WAIT;
                        r_cnt      <= cnt_load(T_LVDS_BL);
                        r_video_en <= 1'b1;
                    end else if (w_cnt_zero) begin
                        // Timing generator dead: no video ever shown, unwind the serializer
                        r_state   <= ST_LVDS_DOWN;
                        r_cnt     <= cnt_load(T_LVDS_VDD);
                        r_lvds_en <= 1'b0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_BL_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_BL_DOWN;
                        r_cnt   <= cnt_load(T_BL_LVDS);
                    end else if (w_cnt_zero) begin
                        r_state        <= ST_RUN;
                        r_backlight_en <= 1'b1;
                        r_ready        <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_state        <= ST_BL_DOWN;
                        r_cnt          <= cnt_load(T_BL_LVDS);
                        r_backlight_en <= 1'b0;
                        r_ready        <= 1'b0;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_BL_DOWN: begin
                    // Power-down stages ignore panel_on so delays are never shortened
                    r_backlight_en <= 1'b0;
                    r_ready        <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state    <= ST_LVDS_DOWN;
                        r_cnt      <= cnt_load(T_LVDS_VDD);
                        r_video_en <= 1'b0;
                        r_lvds_en  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_LVDS_DOWN: begin
                    if (w_cnt_zero) begin
                        r_state     <= ST_OFF_HOLD;
                        r_cnt       <= cnt_load(T_OFF_MIN);
                        r_panel_vdd <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_OFF_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    // Illegal encoding: drop everything and restart from OFF
                    r_state        <= ST_OFF;
                    r_cnt          <= '0;
                    r_panel_vdd    <= 1'b0;
                    r_lvds_en      <= 1'b0;
                    r_video_en     <= 1'b0;
                    r_backlight_en <= 1'b0;
                    r_ready        <= 1'b0;
                end
            endcase
        end
    end

    assign panel_vdd    = r_panel_vdd;
    assign lvds_en      = r_lvds_en;
    assign video_en     = r_video_en;
    assign backlight_en = r_backlight_en;
    assign ready        = r_ready;
    assign fault        = r_fault;

endmodule

// File: tb/tb_panel_power_sequencer.sv
// Scoreboard bench for panel_power_sequencer with scaled delays.
// Output vector {fault, ready, backlight_en, video_en, lvds_en, panel_vdd};
// each stimulus step pushes the expected output changes with the clock edge
// they must occur on, and a monitor pops one entry per observed change.
module tb_panel_power_sequencer;

    localparam logic [5:0] V_OFF   = 6'b000000;
    localparam logic [5:0] V_VDD   = 6'b000001;
    localparam logic [5:0] V_LVDS  = 6'b000011;
    localparam logic [5:0] V_VID   = 6'b000111;
    localparam logic [5:0] V_RUN   = 6'b011111;
    localparam logic [5:0] F_VID   = 6'b100111;
    localparam logic [5:0] F_VDD   = 6'b100001;
    localparam logic [5:0] F_OFF   = 6'b100000;

    typedef struct {
        logic [5:0] vec;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic panel_on;
    logic clk_locked;
    logic vsync;
    logic panel_vdd;
    logic lvds_en;
    logic video_en;
    logic backlight_en;
    logic ready;
    logic fault;
    logic [5:0] outs;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    panel_power_sequencer #(
        .T_VDD_LVDS     (10),
        .T_LVDS_BL      (10),
        .T_BL_LVDS      (10),
        .T_LVDS_VDD     (10),
        .T_OFF_MIN      (20),
        .T_SYNC_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .panel_on     (panel_on),
        .clk_locked   (clk_locked),
        .vsync        (vsync),
        .panel_vdd    (panel_vdd),
        .lvds_en      (lvds_en),
        .video_en     (video_en),
        .backlight_en (backlight_en),
        .ready        (ready),
        .fault        (fault)
    );

    assign outs = {fault, ready, backlight_en, video_en, lvds_en, panel_vdd};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock-edge counter: value N after the Nth rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [5:0] v, input int c);
        exp_t e;
        e.vec = v;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got outputs %b, expected %b", name, got, exp);
        end
    endtask

    // Monitor: every output change must match the head of the scoreboard
    initial begin
        logic [5:0] prev;
        logic [5:0] cur;
        exp_t       e;
        prev = 6'b000000;
        forever begin
            @(negedge clk);
            cur = outs;
            if (cur !== prev) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got outputs %b at edge %0d, expected no change", cur, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if ((e.vec !== cur) || (e.cyc != cyc)) begin
                        n_fail++;
                        $display("FAIL output_event: got %b at edge %0d, expected %b at edge %0d",
                                 cur, cyc, e.vec, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int c, v, s, d, s3, lk, p, s4, q, s5, r;
        rst        = 1'b0;
        panel_on   = 1'b0;
        clk_locked = 1'b0;
        vsync      = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", outs, V_OFF);

        // Power-up straight out of reset: lock must pass the synchroniser first
        clk_locked = 1'b1;
        panel_on   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c   = cyc;
        push(V_VDD,  c + 3);
        push(V_LVDS, c + 13);
        wait_until(c + 18); vsync = 1'b0;
        wait_until(c + 20); vsync = 1'b1; v = cyc;
        push(V_VID, v + 1);
        push(V_RUN, v + 11);

        // Orderly power-down from RUN; panel_on toggles must not shorten it
        wait_until(v + 15); panel_on = 1'b0; s = cyc;
        push(V_VID, s + 1);
        push(V_VDD, s + 11);
        push(V_OFF, s + 21);
        push(V_VDD, s + 42);
        wait_until(s + 5);  panel_on = 1'b1;
        wait_until(s + 8);  panel_on = 1'b0;
        wait_until(s + 25); panel_on = 1'b1;

        // Abort during VDD_UP (5th cycle): lvds_en never rises
        wait_until(s + 46); panel_on = 1'b0; d = cyc;
        push(V_OFF, d + 11);

        // Lock loss in RUN: fault, full power-down, no restart until panel_on low in OFF
        wait_until(d + 35); panel_on = 1'b1; s3 = cyc;
        push(V_VDD,  s3 + 1);
        push(V_LVDS, s3 + 11);
        wait_until(s3 + 16); vsync = 1'b0;
        wait_until(s3 + 18); vsync = 1'b1;
        push(V_VID, s3 + 19);
        push(V_RUN, s3 + 29);
        wait_until(s3 + 35); clk_locked = 1'b0; lk = cyc;
        push(F_VID, lk + 3);
        push(F_VDD, lk + 13);
        push(F_OFF, lk + 23);
        wait_until(lk + 30); clk_locked = 1'b1;
        wait_until(lk + 60); panel_on = 1'b0; p = cyc;
        push(V_OFF, p + 1);

        // VSync stuck high in SYNC_WAIT: timeout fault and orderly power-down
        wait_until(p + 3); panel_on = 1'b1; s4 = cyc;
        push(V_VDD,  s4 + 1);
        push(V_LVDS, s4 + 11);
        push(F_VDD,  s4 + 76);
        push(F_OFF,  s4 + 86);
        wait_until(s4 + 110); panel_on = 1'b0; q = cyc;
        push(V_OFF, q + 1);

        // Reset pulse during BL_WAIT, then a normal power-up
        wait_until(q + 3); panel_on = 1'b1; s5 = cyc;
        push(V_VDD,  s5 + 1);
        push(V_LVDS, s5 + 11);
        wait_until(s5 + 14); vsync = 1'b0;
        wait_until(s5 + 16); vsync = 1'b1;
        push(V_VID, s5 + 17);
        wait_until(s5 + 21);
        #2 rst = 1'b1;
        #1 check("async_reset", outs, V_OFF);
        push(V_OFF, s5 + 22);
        wait_until(s5 + 23); rst = 1'b0; r = cyc;
        push(V_VDD,  r + 3);
        push(V_LVDS, r + 13);
        wait_until(r + 16); vsync = 1'b0;
        wait_until(r + 18); vsync = 1'b1;
        push(V_VID, r + 19);
        push(V_RUN, r + 29);
        wait_until(r + 35);

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d expected changes never seen, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
